// File: rtl/tomasulo_pkg.sv
// Shared constants and entry-state record for the reservation-station dispatch scheduler.
package tomasulo_pkg;

  localparam int unsigned ENTRIES = 4;
  localparam int unsigned POS_W   = 2;

  localparam logic CLASS_SUMSUB = 1'b0;
  localparam logic CLASS_LDSD   = 1'b1;

  typedef struct packed {
    logic             valid;
    logic             is_ldsd;
    logic             in_flight;
    logic [POS_W-1:0] rank;
  } rs_entry_t;

endpackage

// File: rtl/rs_oldest_picker.sv
// Combinational oldest-first selector: returns the eligible entry with the lowest age rank.
module rs_oldest_picker
  import tomasulo_pkg::*;
(
  input  logic [ENTRIES-1:0]       i_elig,
  input  logic [ENTRIES*POS_W-1:0] i_rank,
  output logic                     o_found_c,
  output logic [POS_W-1:0]         o_pos_c
);

  logic [POS_W-1:0] w_best_rank;

  always_comb begin
    o_found_c   = 1'b0;
    o_pos_c     = '0;
    w_best_rank = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (i_elig[i] && (!o_found_c || (i_rank[i*POS_W +: POS_W] < w_best_rank))) begin
        o_found_c   = 1'b1;
        o_pos_c     = POS_W'(i);
        w_best_rank = i_rank[i*POS_W +: POS_W];
      end
    end
  end

endmodule

// File: rtl/rs_dispatch_scheduler.sv
// Oldest-first dispatch for the 4-entry reservation station: age ranks, in-flight tracking,
// per-unit occupancy counters, issue-stall and sticky allocation-error flag.
module rs_dispatch_scheduler
  import tomasulo_pkg::*;
#(
  parameter int unsigned LAT_SUMSUB = 1,
  parameter int unsigned LAT_LDSD   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alloc_valid,
  input  logic [POS_W-1:0]   alloc_pos,
  input  logic               alloc_is_ldsd,
  input  logic [ENTRIES-1:0] rs_ready,
  input  logic               free_valid,
  input  logic [POS_W-1:0]   free_pos,
  output logic               sumsub_issue,
  output logic [POS_W-1:0]   sumsub_pos,
  output logic               ldsd_issue,
  output logic [POS_W-1:0]   ldsd_pos,
  output logic               stall,
  output logic               alloc_err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned NUM_W = POS_W + 1;

  rs_entry_t                r_ent     [ENTRIES];
  rs_entry_t                w_ent_nxt [ENTRIES];
  logic [CNT_W-1:0]         r_ss_cnt, r_ls_cnt, w_ss_cnt_nxt, w_ls_cnt_nxt;
  logic                     w_free_hit, w_alloc_ok, w_alloc_bad;
  logic [ENTRIES-1:0]       w_freeing, w_ss_elig, w_ls_elig;
  logic [ENTRIES*POS_W-1:0] w_rank_flat;
  logic [NUM_W-1:0]         w_cnt_free, w_cnt_nxt;
  logic                     w_ss_found, w_ls_found;
  logic [POS_W-1:0]         w_ss_pos, w_ls_pos;

  assign w_free_hit  = free_valid & r_ent[free_pos].valid;
  assign w_alloc_ok  = alloc_valid & ~r_ent[alloc_pos].valid;
  assign w_alloc_bad = alloc_valid & r_ent[alloc_pos].valid;

  // Per-unit eligibility; an entry retiring at this edge must not dispatch.
  always_comb begin
    w_freeing   = '0;
    w_ss_elig   = '0;
    w_ls_elig   = '0;
    w_rank_flat = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_freeing[i] = w_free_hit && (free_pos == POS_W'(i));
      w_rank_flat[i*POS_W +: POS_W] = r_ent[i].rank;
      w_ss_elig[i] = r_ent[i].valid && rs_ready[i] && !r_ent[i].in_flight && !w_freeing[i]
                     && (r_ent[i].is_ldsd == CLASS_SUMSUB) && (r_ss_cnt == '0);
      w_ls_elig[i] = r_ent[i].valid && rs_ready[i] && !r_ent[i].in_flight && !w_freeing[i]
                     && (r_ent[i].is_ldsd == CLASS_LDSD) && (r_ls_cnt == '0);
    end
  end

  rs_oldest_picker u_pick_sumsub (
    .i_elig    (w_ss_elig),
    .i_rank    (w_rank_flat),
    .o_found_c (w_ss_found),
    .o_pos_c   (w_ss_pos)
  );

  rs_oldest_picker u_pick_ldsd (
    .i_elig    (w_ls_elig),
    .i_rank    (w_rank_flat),
    .o_found_c (w_ls_found),
    .o_pos_c   (w_ls_pos)
  );

  // Next state: free and compact ranks first, then mark dispatches, then place the new entry.
  always_comb begin
    w_cnt_free = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_ent_nxt[i] = r_ent[i];
      if (w_freeing[i]) begin
        w_ent_nxt[i].valid     = 1'b0;
        w_ent_nxt[i].in_flight = 1'b0;
      end else if (w_free_hit && r_ent[i].valid && (r_ent[i].rank > r_ent[free_pos].rank)) begin
        w_ent_nxt[i].rank = r_ent[i].rank - POS_W'(1);
      end
      if ((w_ss_found && (w_ss_pos == POS_W'(i))) || (w_ls_found && (w_ls_pos == POS_W'(i)))) begin
        w_ent_nxt[i].in_flight = 1'b1;
      end
      w_cnt_free = w_cnt_free + NUM_W'(w_ent_nxt[i].valid);
    end
    if (w_alloc_ok) begin
      w_ent_nxt[alloc_pos].valid     = 1'b1;
      w_ent_nxt[alloc_pos].is_ldsd   = alloc_is_ldsd;
      w_ent_nxt[alloc_pos].in_flight = 1'b0;
      w_ent_nxt[alloc_pos].rank      = POS_W'(w_cnt_free);
    end
    w_cnt_nxt = w_cnt_free + NUM_W'(w_alloc_ok);

    w_ss_cnt_nxt = r_ss_cnt;
    if (w_ss_found)           w_ss_cnt_nxt = CNT_W'(LAT_SUMSUB - 1);
    else if (r_ss_cnt != '0)  w_ss_cnt_nxt = r_ss_cnt - CNT_W'(1);
    w_ls_cnt_nxt = r_ls_cnt;
    if (w_ls_found)           w_ls_cnt_nxt = CNT_W'(LAT_LDSD - 1);
    else if (r_ls_cnt != '0)  w_ls_cnt_nxt = r_ls_cnt - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) r_ent[i] <= '0;
      r_ss_cnt     <= '0;
      r_ls_cnt     <= '0;
      sumsub_issue <= 1'b0;
      sumsub_pos   <= '0;
      ldsd_issue   <= 1'b0;
      ldsd_pos     <= '0;
      stall        <= 1'b0;
      alloc_err    <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) r_ent[i] <= w_ent_nxt[i];
      r_ss_cnt     <= w_ss_cnt_nxt;
      r_ls_cnt     <= w_ls_cnt_nxt;
      sumsub_issue <= w_ss_found;
      ldsd_issue   <= w_ls_found;
      if (w_ss_found) sumsub_pos <= w_ss_pos;
      if (w_ls_found) ldsd_pos   <= w_ls_pos;
      stall        <= (w_cnt_nxt == NUM_W'(ENTRIES));
      alloc_err    <= alloc_err | w_alloc_bad;
    end
  end

endmodule
